mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//  Memory-side responder for single_cycle_mips: serves the CPU instruction fetch port and data load/store port.
//  Includes a byte-stream program loader FSM that fills instruction memory while holding the CPU in reset.
//  Sits beside the CPU at top level; its inst / data ports connect one-to-one to the CPU memory pins.
// PARAMETERS
//  IMEM_WORDS  256  instruction memory depth in 32-bit words (power of 2)
//  DMEM_WORDS  256  data memory depth in 32-bit words (power of 2)
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  rst_n        in   1   reset, asynchronous, active-low
//  inst_addr    in   32  CPU fetch byte address
//  inst         out  32  instruction word at inst_addr
//  data_addr    in   32  CPU load/store byte address
//  data_wdata   in   32  store data (CPU data_out)
//  data_wr      in   1   store enable
//  data_rdata   out  32  load data (CPU data_in)
//  ld_start     in   1   single-cycle pulse: begin program load
//  ld_valid     in   1   ld_byte is valid
//  ld_ready     out  1   loader accepts a byte this cycle
//  ld_byte      in   8   program byte; big-endian within each word
//  ld_last      in   1   qualifies the final byte of the image
//  cpu_rst_n    out  1   CPU reset, active-low, registered
//  load_done    out  1   single-cycle pulse: load finished
//  err_align    out  1   sticky: misaligned or out-of-range data store seen
//  err_ovf      out  1   sticky: load image exceeded IMEM_WORDS
// BEHAVIOUR
//  Reset values: ld_ready=0, load_done=0, cpu_rst_n=0, err_align=0, err_ovf=0, FSM=IDLE, byte_cnt=0, wptr=0.
//   Memory arrays are not reset; contents persist across rst_n and are undefined after power-up.
//  Fetch: inst = imem[inst_addr[log2(IMEM_WORDS)+1:2]], combinational, zero wait.
//   Address beyond IMEM_WORDS*4 returns 32'h0000_0000 (NOP); inst_addr[1:0] is ignored.
//  Load: data_rdata = dmem[data_addr word index], combinational. Out-of-range address returns 0.
//  Store: dmem written on the posedge where data_wr=1.
//   If data_addr[1:0]!=0 or the address is out of range: write suppressed, err_align set.
//   Same-cycle read of the stored address returns the old value; the new value is visible after the edge.
//  Loader FSM, three states:
//   IDLE -> LOAD on ld_start: byte_cnt=0, wptr=0, cpu_rst_n<=0.
//   LOAD: ld_ready=1. A byte is accepted when ld_valid & ld_ready.
//    Byte k of a word (k=0..3) goes to bits [31-8k -: 8].
//    On the 4th byte, the assembled word is written to imem[wptr] and wptr increments.
//    ld_last with a byte: a partial word is zero-padded and written; FSM -> DONE.
//    When wptr==IMEM_WORDS, later bytes are accepted and dropped, and err_ovf is set.
//    ld_start while in LOAD is ignored.
//   DONE: load_done=1 for exactly one cycle, cpu_rst_n<=1, FSM -> IDLE.
//   IDLE: cpu_rst_n=1 from the first clock after rst_n deasserts; ld_ready=0.
//  Latency: a loader write to imem is visible on inst in the cycle after the writing edge.
//  Simultaneous events: CPU stores proceed during LOAD because dmem is independent. ld_valid in IDLE is ignored.
//  rst_n asserted mid-load: load aborts, the partial word is discarded, words already written are kept,
//   cpu_rst_n=0 until the first clock after rst_n releases.
//  err flags clear only on rst_n.
// STRUCTURE
//  Package mips_mem_pkg: IMEM_WORDS/DMEM_WORDS defaults, loader state enum {IDLE,LOAD,DONE},
//   NOP_WORD=32'h0, address-index helper widths.
//  Sub-module mips_word_assembler: byte shifter + byte_cnt; outputs word, word_valid, partial flush on last.
//  Top module: imem/dmem arrays, store/error logic, loader FSM.
// TESTING
//  Load bytes 8C,01,00,04, 00,00,00,20 (ld_last on the 8th byte) -> imem[0]=8C010004, imem[1]=00000020;
//   load_done pulses once; cpu_rst_n is low throughout LOAD and high the cycle after DONE.
//  Load 5 bytes AA,BB,CC,DD,11 with last on 11 -> imem[1]=11000000; wptr=2.
//  Store data_addr=0x10, wdata=0xDEADBEEF -> data_rdata at 0x10 reads DEADBEEF the next cycle.
//   The same-cycle read shows the old value.
//  Store to 0x13 and to DMEM_WORDS*4 -> dmem unchanged; err_align=1 and stays 1 until rst_n.
//  Stream IMEM_WORDS*4+4 bytes -> err_ovf=1; imem[0..IMEM_WORDS-1] intact; load still completes on ld_last.
//  Assert rst_n after 6 bytes of a load -> FSM=IDLE, imem[0] kept, imem[1] unchanged;
//   ld_ready=0 and cpu_rst_n=0 during reset.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared constants, loader state type and index helpers
package mips_mem_pkg;

  localparam int IMEM_WORDS_DEF = 256;
  localparam int DMEM_WORDS_DEF = 256;

  // A fetch outside instruction memory must execute as a harmless no-op.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  // Word-index width for a memory of the given depth (depth is a power of 2).
  function automatic int idx_width(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// rtl/mips_mem_responder_if.sv - CPU memory pins plus program-loader stream and status
interface mips_mem_responder_if;

  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_wr;
  logic [31:0] data_rdata;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        cpu_rst_n;
  logic        load_done;
  logic        err_align;
  logic        err_ovf;

  // CPU and program source side
  modport master (
    output inst_addr, data_addr, data_wdata, data_wr,
    output ld_start, ld_valid, ld_byte, ld_last,
    input  inst, data_rdata, ld_ready, cpu_rst_n, load_done, err_align, err_ovf
  );

  // Memory responder side
  modport slave (
    input  inst_addr, data_addr, data_wdata, data_wr,
    input  ld_start, ld_valid, ld_byte, ld_last,
    output inst, data_rdata, ld_ready, cpu_rst_n, load_done, err_align, err_ovf
  );

endinterface

// File: rtl/mips_word_assembler.sv
// rtl/mips_word_assembler.sv - packs a big-endian byte stream into 32-bit words
module mips_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] acc;
  logic [1:0]  byte_cnt;
  logic [31:0] placed;

  // Drop the incoming byte into its big-endian lane and merge with bytes already held
  always_comb begin
    placed = 32'h0;
    case (byte_cnt)
      2'd0:    placed = {in_byte, 24'h0};
      2'd1:    placed = {8'h0, in_byte, 16'h0};
      2'd2:    placed = {16'h0, in_byte, 8'h0};
      default: placed = {24'h0, in_byte};
    endcase
    word       = acc | placed;
    // A word completes on its fourth byte, or early (zero-padded) on the last byte
    word_valid = in_valid && ((byte_cnt == 2'd3) || in_last);
  end

  // Hold the partial word; reset discards it, completion or clear starts a fresh one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 32'h0;
      byte_cnt <= 2'd0;
    end else if (clear || word_valid) begin
      acc      <= 32'h0;
      byte_cnt <= 2'd0;
    end else if (in_valid) begin
      acc      <= word;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - instruction/data memories, store checking and program loader
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  mips_mem_responder_if.slave bus
);

  localparam int IAW = idx_width(IMEM_WORDS);
  localparam int DAW = idx_width(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  ld_state_e   state, state_next;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        ld_ready_c, load_done_c, start_load;
  logic        accept;
  logic [IAW:0] wptr;
  logic        err_align_q, err_ovf_q;
  logic [31:0] asm_word;
  logic        asm_word_valid;

  logic [IAW-1:0] inst_idx;
  logic           inst_in_range;
  logic [DAW-1:0] data_idx;
  logic           data_in_range;
  logic           store_ok;
  logic           unused_inst_lsbs;

  // ---------------- fetch and load port ----------------
  assign inst_idx         = bus.inst_addr[IAW+1:2];
  assign inst_in_range    = (bus.inst_addr[31:IAW+2] == '0);
  assign unused_inst_lsbs = ^bus.inst_addr[1:0];
  assign bus.inst         = inst_in_range ? imem[inst_idx] : NOP_WORD;

  assign data_idx       = bus.data_addr[DAW+1:2];
  assign data_in_range  = (bus.data_addr[31:DAW+2] == '0);
  assign bus.data_rdata = data_in_range ? dmem[data_idx] : 32'h0;

  // Only aligned, in-range stores reach memory; everything else is flagged
  assign store_ok = bus.data_wr && (bus.data_addr[1:0] == 2'b00) && data_in_range;

  // Data memory write; a same-cycle read still sees the old word
  always_ff @(posedge clk) begin
    if (store_ok) begin
      dmem[data_idx] <= bus.data_wdata;
    end
  end

  // Sticky flag for rejected stores, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_align_q <= 1'b0;
    end else if (bus.data_wr && !store_ok) begin
      err_align_q <= 1'b1;
    end
  end

  // ---------------- program loader ----------------
  assign accept     = bus.ld_valid && ld_ready_c;
  assign start_load = (state == IDLE) && bus.ld_start;

  mips_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_load),
    .in_valid   (accept),
    .in_byte    (bus.ld_byte),
    .in_last    (bus.ld_last),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  // Loader state register and registered CPU reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state       <= state_next;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // Loader next state; the CPU is held in reset for the whole load
  always_comb begin
    state_next  = state;
    ld_ready_c  = 1'b0;
    load_done_c = 1'b0;
    cpu_rst_n_d = 1'b0;
    case (state)
      IDLE: begin
        cpu_rst_n_d = !bus.ld_start;
        if (bus.ld_start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        ld_ready_c = 1'b1;
        if (bus.ld_valid && bus.ld_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        load_done_c = 1'b1;
        cpu_rst_n_d = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write pointer saturates at IMEM_WORDS so excess image bytes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (start_load) begin
      wptr <= '0;
    end else if (asm_word_valid && !wptr[IAW]) begin
      wptr <= wptr + {{IAW{1'b0}}, 1'b1};
    end
  end

  // Instruction memory fill from the assembler while space remains
  always_ff @(posedge clk) begin
    if (asm_word_valid && !wptr[IAW]) begin
      imem[wptr[IAW-1:0]] <= asm_word;
    end
  end

  // Sticky overflow flag: any byte accepted once memory is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
    end else if (accept && wptr[IAW]) begin
      err_ovf_q <= 1'b1;
    end
  end

  assign bus.ld_ready  = ld_ready_c;
  assign bus.load_done = load_done_c;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.err_align = err_align_q;
  assign bus.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed bench with a reference model of the memory responder
module tb_mips_mem_responder;

  localparam int IW = 256;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_mem_responder_if bus ();

  mips_mem_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  m_imem [IW];
  bit           m_ik [IW];
  logic [31:0]  m_dmem [DW];
  bit           m_dk [DW];
  int           m_phase = 0;      // 0 idle, 1 loading, 2 finishing
  bit           m_cpu_rst_n = 1'b0;
  bit           m_err_align = 1'b0;
  bit           m_err_ovf = 1'b0;
  byte unsigned m_part[$];
  int           m_words = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] w;
    if (!rst_n) begin
      m_phase = 0;
      m_cpu_rst_n = 1'b0;
      m_err_align = 1'b0;
      m_err_ovf = 1'b0;
      m_part.delete();
    end else begin
      if (bus.data_wr) begin
        if (bus.data_addr[1:0] == 2'b00 && bus.data_addr < 32'(DW * 4)) begin
          m_dmem[bus.data_addr >> 2] = bus.data_wdata;
          m_dk[bus.data_addr >> 2] = 1'b1;
        end else begin
          m_err_align = 1'b1;
        end
      end
      case (m_phase)
        0: begin
          m_cpu_rst_n = !bus.ld_start;
          if (bus.ld_start) begin
            m_phase = 1;
            m_words = 0;
            m_part.delete();
          end
        end
        1: begin
          m_cpu_rst_n = 1'b0;
          if (bus.ld_valid) begin
            if (m_words >= IW) m_err_ovf = 1'b1;
            m_part.push_back(bus.ld_byte);
            if (m_part.size() == 4 || bus.ld_last) begin
              w = 32'h0;
              foreach (m_part[i]) w = w | (32'(m_part[i]) << (24 - 8 * i));
              if (m_words < IW) begin
                m_imem[m_words] = w;
                m_ik[m_words] = 1'b1;
                m_words++;
              end
              m_part.delete();
            end
            if (bus.ld_last) m_phase = 2;
          end
        end
        default: begin
          m_cpu_rst_n = 1'b1;
          m_phase = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [31:0] ia, da;
    check("ld_ready", {31'h0, bus.ld_ready}, {31'h0, m_phase == 1});
    check("load_done", {31'h0, bus.load_done}, {31'h0, m_phase == 2});
    check("cpu_rst_n", {31'h0, bus.cpu_rst_n}, {31'h0, m_cpu_rst_n});
    check("err_align", {31'h0, bus.err_align}, {31'h0, m_err_align});
    check("err_ovf", {31'h0, bus.err_ovf}, {31'h0, m_err_ovf});
    ia = bus.inst_addr;
    if (ia >= 32'(IW * 4)) check("inst_oor", bus.inst, 32'h0);
    else if (m_ik[ia >> 2]) check("inst", bus.inst, m_imem[ia >> 2]);
    da = bus.data_addr;
    if (da >= 32'(DW * 4)) check("rdata_oor", bus.data_rdata, 32'h0);
    else if (m_dk[da >> 2]) check("rdata", bus.data_rdata, m_dmem[da >> 2]);
    if (bus.load_done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus ----------------
  byte unsigned ld_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit use_last, input int restart_at);
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    foreach (ld_q[i]) begin
      bus.ld_valid = 1'b1;
      bus.ld_byte  = ld_q[i];
      bus.ld_last  = use_last && (i == ld_q.size() - 1);
      bus.ld_start = (i == restart_at);
      if (i == 0) check("cpu_rst_n_in_load", {31'h0, bus.cpu_rst_n}, 32'h0);
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_start = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wd);
    bus.data_addr  = addr;
    bus.data_wdata = wd;
    bus.data_wr    = 1'b1;
    step();
    bus.data_wr    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.inst_addr = 32'h0; bus.data_addr = 32'h0; bus.data_wdata = 32'h0; bus.data_wr = 1'b0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_byte = 8'h0; bus.ld_last = 1'b0;

    // Reset values
    @(negedge clk); #1;
    check("rst_cpu_rst_n", {31'h0, bus.cpu_rst_n}, 32'h0);
    check("rst_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
    check("rst_load_done", {31'h0, bus.load_done}, 32'h0);
    check("rst_errs", {30'h0, bus.err_align, bus.err_ovf}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_cpu_rst_n", {31'h0, bus.cpu_rst_n}, 32'h1);

    // Two-word image
    ld_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h20};
    d0 = done_cnt;
    run_load(1'b1, -1);
    step(); step();
    check("load1_done_once", 32'(done_cnt - d0), 32'h1);
    check("load1_cpu_rst_n", {31'h0, bus.cpu_rst_n}, 32'h1);
    bus.inst_addr = 32'h0; #1;
    check("load1_imem0", bus.inst, 32'h8C010004);
    bus.inst_addr = 32'h4; #1;
    check("load1_imem1", bus.inst, 32'h00000020);

    // ld_valid in IDLE is ignored
    bus.ld_valid = 1'b1; bus.ld_byte = 8'h77; bus.ld_last = 1'b1;
    step(); step();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    bus.inst_addr = 32'h0; #1;
    check("idle_valid_ignored", bus.inst, 32'h8C010004);

    // Partial word padding, restart ignored mid-load, concurrent store
    ld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    fork
      run_load(1'b1, 2);
      begin step(); step(); store(32'h20, 32'hCAFEF00D); end
    join
    step(); step();
    bus.inst_addr = 32'h0; #1;
    check("load2_imem0", bus.inst, 32'hAABBCCDD);
    bus.inst_addr = 32'h7; #1;
    check("load2_imem1_pad", bus.inst, 32'h11000000);
    bus.data_addr = 32'h20; #1;
    check("store_during_load", bus.data_rdata, 32'hCAFEF00D);

    // Store visibility
    store(32'h10, 32'h12345678);
    bus.data_wdata = 32'hDEADBEEF; bus.data_wr = 1'b1; #1;
    check("store_same_cycle_old", bus.data_rdata, 32'h12345678);
    step();
    bus.data_wr = 1'b0; #1;
    check("store_next_cycle", bus.data_rdata, 32'hDEADBEEF);
    check("err_align_clear", {31'h0, bus.err_align}, 32'h0);

    // Rejected stores
    store(32'h13, 32'hFFFFFFFF);
    check("err_align_mis", {31'h0, bus.err_align}, 32'h1);
    bus.data_addr = 32'h10; #1;
    check("mis_no_write", bus.data_rdata, 32'hDEADBEEF);
    store(32'(DW * 4), 32'hFFFFFFFF);
    check("oor_read_zero", bus.data_rdata, 32'h0);
    step(); step();
    check("err_align_sticky", {31'h0, bus.err_align}, 32'h1);
    bus.data_addr = 32'h10; #1;
    check("oor_no_write", bus.data_rdata, 32'hDEADBEEF);

    // Reset in the middle of a load
    ld_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(1'b0, -1);
    rst_n = 1'b0; #1;
    check("midrst_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
    check("midrst_cpu_rst_n", {31'h0, bus.cpu_rst_n}, 32'h0);
    step(); step();
    check("midrst_cpu_rst_n_hold", {31'h0, bus.cpu_rst_n}, 32'h0);
    rst_n = 1'b1;
    step();
    check("midrst_cpu_rst_n_rel", {31'h0, bus.cpu_rst_n}, 32'h1);
    check("midrst_err_align_cleared", {31'h0, bus.err_align}, 32'h0);
    bus.inst_addr = 32'h0; #1;
    check("midrst_imem0_kept", bus.inst, 32'h01020304);
    bus.inst_addr = 32'h4; #1;
    check("midrst_imem1_unchanged", bus.inst, 32'h11000000);

    // Overflowing image
    ld_q.delete();
    for (int i = 0; i < IW * 4 + 4; i++) ld_q.push_back(8'((i * 7 + 3) & 8'hFF));
    d0 = done_cnt;
    run_load(1'b1, -1);
    step(); step();
    check("ovf_flag", {31'h0, bus.err_ovf}, 32'h1);
    check("ovf_done_once", 32'(done_cnt - d0), 32'h1);
    check("ovf_cpu_rst_n", {31'h0, bus.cpu_rst_n}, 32'h1);
    bus.inst_addr = 32'h0; #1;
    check("ovf_imem0", bus.inst, 32'h030A1118);
    bus.inst_addr = 32'(IW * 4 - 4); #1;
    check("ovf_imem_last", bus.inst, 32'hE7EEF5FC);
    for (int a = 0; a < IW; a++) begin
      bus.inst_addr = 32'(a * 4); #1;
      check("ovf_imem_scan", bus.inst, m_imem[a]);
    end
    bus.inst_addr = 32'(IW * 4); #1;
    check("inst_oor_nop", bus.inst, 32'h0);

    // Flags clear only on reset
    step(); step();
    check("ovf_sticky", {31'h0, bus.err_ovf}, 32'h1);
    rst_n = 1'b0; #1;
    check("ovf_cleared", {31'h0, bus.err_ovf}, 32'h0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
